// File: rtl/bw_clk_gl_pkg.sv
// Shared types and constants for the clock-grid column enable sequencer.
// Optional feature macro: BW_CLK_GL_SEQ_MASK_EN (per-column skip mask).
package bw_clk_gl_pkg;

    localparam int NUM_COL = 4;
    localparam int NUM_DOM = 3;
    localparam int GAP_W   = 4;
    localparam int COL_W   = $clog2(NUM_COL);

    // Bit positions inside dom_sel and the internal per-domain enable set
    localparam int DOM_CMP  = 0;
    localparam int DOM_DDR  = 1;
    localparam int DOM_JBUS = 2;

    localparam logic [COL_W-1:0] COL_FIRST = '0;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COL - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RAMP_DN = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/bw_clk_gl_seq_tmr.sv
// Inter-column gap timer: loads G, counts down to zero, flags the last cycle of a step.
// Unaffected by BW_CLK_GL_SEQ_MASK_EN.
module bw_clk_gl_seq_tmr
    import bw_clk_gl_pkg::*;
(
    input  logic             gclk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    output logic             expired
);

    logic [GAP_W-1:0] cnt_reg;

    // Saturates at zero so the count can never wrap inside a step
    always_ff @(posedge gclk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/bw_clk_gl_seq.sv
// Column clock-enable ramp sequencer for the cmp/ddr/jbus grid domains.
// Define BW_CLK_GL_SEQ_MASK_EN to add the col_mask skip input.
module bw_clk_gl_seq
    import bw_clk_gl_pkg::*;
(
    input  logic               gclk,
    input  logic               rst,
    input  logic               start_req,
    input  logic               stop_req,
    input  logic [NUM_DOM-1:0] dom_sel,
    input  logic [GAP_W-1:0]   gap_cfg,
`ifdef BW_CLK_GL_SEQ_MASK_EN
    input  logic [NUM_COL-1:0] col_mask,
`endif
    output logic [NUM_COL-1:0] col_en_cmp,
    output logic [NUM_COL-1:0] col_en_ddr,
    output logic [NUM_COL-1:0] col_en_jbus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   col_idx_reg, col_idx_next;
    logic [NUM_DOM-1:0] dom_reg, dom_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [NUM_COL-1:0] mask_reg, mask_next;
    logic               err_reg, err_next;
    logic [NUM_COL-1:0] mask_in;

    logic               tmr_load;
    logic [GAP_W-1:0]   tmr_val;
    logic               tmr_expired;

    // One enable update per step, applied on the edge that opens the step
    logic               apply_vld;
    logic               apply_set;
    logic [COL_W-1:0]   apply_col;
    logic [NUM_DOM-1:0] apply_dom;
    logic [NUM_COL-1:0] apply_mask;

`ifdef BW_CLK_GL_SEQ_MASK_EN
    assign mask_in = col_mask;
`else
    assign mask_in = '0;
`endif

    bw_clk_gl_seq_tmr u_tmr (
        .gclk     (gclk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_next   = state_reg;
        col_idx_next = col_idx_reg;
        dom_next     = dom_reg;
        gap_next     = gap_reg;
        mask_next    = mask_reg;
        err_next     = err_reg;
        tmr_load     = 1'b0;
        tmr_val      = gap_reg;
        apply_vld    = 1'b0;
        apply_set    = 1'b0;
        apply_col    = col_idx_reg;
        apply_dom    = dom_reg;
        apply_mask   = mask_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_req && stop_req) begin
                    err_next = 1'b1;
                end else if (start_req || stop_req) begin
                    state_next   = start_req ? ST_RAMP_UP : ST_RAMP_DN;
                    col_idx_next = start_req ? COL_FIRST : COL_LAST;
                    dom_next     = dom_sel;
                    gap_next     = gap_cfg;
                    mask_next    = mask_in;
                    tmr_load     = 1'b1;
                    tmr_val      = gap_cfg;
                    apply_vld    = 1'b1;
                    apply_set    = start_req;
                    apply_col    = col_idx_next;
                    apply_dom    = dom_sel;
                    apply_mask   = mask_in;
                end
            end
            ST_RAMP_UP, ST_RAMP_DN: begin
                if (start_req || stop_req) begin
                    err_next = 1'b1;
                end
                if (tmr_expired) begin
                    if (col_idx_reg == ((state_reg == ST_RAMP_UP) ? COL_LAST : COL_FIRST)) begin
                        state_next = ST_FINISH;
                    end else begin
                        col_idx_next = (state_reg == ST_RAMP_UP) ? col_idx_reg + 1'b1
                                                                 : col_idx_reg - 1'b1;
                        tmr_load     = 1'b1;
                        apply_vld    = 1'b1;
                        apply_set    = (state_reg == ST_RAMP_UP);
                        apply_col    = col_idx_next;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            col_idx_reg <= '0;
            dom_reg     <= '0;
            gap_reg     <= '0;
            mask_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_idx_reg <= col_idx_next;
            dom_reg     <= dom_next;
            gap_reg     <= gap_next;
            mask_reg    <= mask_next;
            err_reg     <= err_next;
        end
    end

    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
        logic [NUM_COL-1:0] en_reg;

        always_ff @(posedge gclk) begin
            if (rst) begin
                en_reg <= '0;
            end else if (apply_vld && apply_dom[gi] && !apply_mask[apply_col]) begin
                en_reg[apply_col] <= apply_set;
            end
        end
    end

    assign col_en_cmp  = g_dom[DOM_CMP].en_reg;
    assign col_en_ddr  = g_dom[DOM_DDR].en_reg;
    assign col_en_jbus = g_dom[DOM_JBUS].en_reg;
    assign busy        = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DN);
    assign done        = (state_reg == ST_FINISH);
    assign err         = err_reg;

endmodule

// File: tb/tb_bw_clk_gl_seq.sv
// Scoreboard bench for bw_clk_gl_seq; BW_CLK_GL_SEQ_MASK_EN enables the mask scenario.
module tb_bw_clk_gl_seq;

    logic       gclk;
    logic       rst;
    logic       start_req;
    logic       stop_req;
    logic [2:0] dom_sel;
    logic [3:0] gap_cfg;
    logic [3:0] mask_drv;
    logic [3:0] col_en_cmp, col_en_ddr, col_en_jbus;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [14:0] val;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_en[3];
    logic       m_err;

    bw_clk_gl_seq dut (
        .gclk        (gclk),
        .rst         (rst),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .dom_sel     (dom_sel),
        .gap_cfg     (gap_cfg),
`ifdef BW_CLK_GL_SEQ_MASK_EN
        .col_mask    (mask_drv),
`endif
        .col_en_cmp  (col_en_cmp),
        .col_en_ddr  (col_en_ddr),
        .col_en_jbus (col_en_jbus),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    always @(posedge gclk) cyc <= cyc + 1;

    // Scoreboard consumer: one expected snapshot per cycle, compared mid-cycle
    always @(negedge gclk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [14:0] got;
            e   = sb.pop_front();
            got = {col_en_jbus, col_en_ddr, col_en_cmp, busy, done, err};
            checks++;
            if (e.cyc != cyc || got !== e.val) begin
                errors++;
                $display("FAIL sb_%s cyc=%0d exp_cyc=%0d got jbus/ddr/cmp/busy/done/err=%b required=%b",
                         e.tag, cyc, e.cyc, got, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic push_state(input int c, input logic b, input logic d, input logic er, input string tag);
        exp_t e;
        e.cyc = c;
        e.val = {m_en[2], m_en[1], m_en[0], b, d, er};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected trajectory: column j of the ramp becomes visible at t+1+j*(G+1)
    task automatic push_ramp(input int t, input logic up, input logic [2:0] d, input int g,
                             input logic [3:0] m, input int err_at, input string tag);
        logic [3:0] en[3];
        int         stp;
        int         last;
        stp  = g + 1;
        last = t + 4 * stp;
        en   = m_en;
        for (int c = t + 1; c <= last + 2; c++) begin
            int   k;
            int   col;
            exp_t e;
            k  = (c <= last) ? ((c - t - 1) / stp + 1) : 4;
            en = m_en;
            for (int dd = 0; dd < 3; dd++) begin
                for (int j = 0; j < k; j++) begin
                    col = up ? j : 3 - j;
                    if (d[dd] && !m[col]) en[dd][col] = up;
                end
            end
            e.cyc = c;
            e.val = {en[2], en[1], en[0], (c <= last), (c == last + 1),
                     (m_err || (err_at > 0 && c >= t + err_at))};
            e.tag = tag;
            sb.push_back(e);
        end
        m_en = en;
        if (err_at > 0) m_err = 1'b1;
    endtask

    task automatic issue_req(input logic up, input logic [2:0] d, input logic [3:0] g,
                             input logic [3:0] m, input int err_at, input string tag, output int t);
        logic [3:0] mm;
`ifdef BW_CLK_GL_SEQ_MASK_EN
        mm = m;
`else
        mm = 4'b0000;
`endif
        t         = cyc;
        start_req = up;
        stop_req  = !up;
        dom_sel   = d;
        gap_cfg   = g;
        mask_drv  = m;
        push_ramp(t, up, d, int'(g), mm, err_at, tag);
        step(1);
        start_req = 1'b0;
        stop_req  = 1'b0;
    endtask

    task automatic wait_drain(output bit to, output int done_cyc, output int done_cnt);
        done_cyc = -1;
        done_cnt = 0;
        for (int i = 0; i < 300 && sb.size() > 0; i++) begin
            @(negedge gclk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        to = (sb.size() != 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        sb.delete();
        step(n);
        rst = 1'b0;
        for (int dd = 0; dd < 3; dd++) m_en[dd] = 4'b0000;
        m_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        checks++;
        if ({col_en_jbus, col_en_ddr, col_en_cmp, busy, done, err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got=%b required=0", {col_en_jbus, col_en_ddr, col_en_cmp, busy, done, err});
        end
        do_reset(1);
        push_state(cyc + 1, 1'b0, 1'b0, 1'b0, "post_reset_idle");
        push_state(cyc + 2, 1'b0, 1'b0, 1'b0, "post_reset_idle");
        step(3);
    endtask

    task automatic test_ramp_up_g2;
        int t, dc, dn;
        bit to;
        while (cyc < 10) step(1);
        issue_req(1'b1, 3'b111, 4'd2, 4'b0000, 0, "up_g2", t);
        wait_drain(to, dc, dn);
        checks++;
        if (to || dc != 23 || dn != 1) begin
            errors++;
            $display("FAIL up_g2_done timeout=%0d done_cyc=%0d count=%0d required cyc 23 count 1", to, dc, dn);
        end
        step(1);
    endtask

    task automatic test_idempotent;
        int t, dc, dn;
        bit to;
        issue_req(1'b1, 3'b111, 4'd0, 4'b0000, 0, "idem_up", t);
        wait_drain(to, dc, dn);
        checks++;
        if (to || err !== 1'b0 || col_en_cmp !== 4'b1111 || dn != 1) begin
            errors++;
            $display("FAIL idem_up timeout=%0d err=%b cmp=%b done_count=%0d required err 0 cmp 1111 count 1",
                     to, err, col_en_cmp, dn);
        end
        step(1);
    endtask

    task automatic test_ramp_dn_g0;
        int t, dc, dn;
        bit to;
        issue_req(1'b0, 3'b010, 4'd0, 4'b0000, 0, "dn_g0", t);
        wait_drain(to, dc, dn);
        checks++;
        if (to || dc != t + 5 || col_en_ddr !== 4'b0000 || col_en_cmp !== 4'b1111 || col_en_jbus !== 4'b1111) begin
            errors++;
            $display("FAIL dn_g0 timeout=%0d done_cyc=%0d ddr=%b cmp=%b jbus=%b required cyc %0d 0000 1111 1111",
                     to, dc, col_en_ddr, col_en_cmp, col_en_jbus, t + 5);
        end
        step(1);
    endtask

    task automatic test_both_req;
        int t, dc, dn;
        bit to;
        t         = cyc;
        start_req = 1'b1;
        stop_req  = 1'b1;
        dom_sel   = 3'b111;
        gap_cfg   = 4'd0;
        m_err     = 1'b1;
        push_state(t + 1, 1'b0, 1'b0, 1'b1, "both_req");
        push_state(t + 2, 1'b0, 1'b0, 1'b1, "both_req");
        step(1);
        start_req = 1'b0;
        stop_req  = 1'b0;
        @(negedge gclk);
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_req err=%b busy=%b required err 1 busy 0", err, busy);
        end
        step(2);
        issue_req(1'b1, 3'b010, 4'd1, 4'b0000, 0, "clean_after_err", t);
        wait_drain(to, dc, dn);
        checks++;
        if (to || err !== 1'b1 || col_en_ddr !== 4'b1111 || dn != 1) begin
            errors++;
            $display("FAIL err_sticky timeout=%0d err=%b ddr=%b done_count=%0d required 1 1111 1", to, err, col_en_ddr, dn);
        end
        step(1);
    endtask

    task automatic test_rst_midramp;
        int t, dn;
        do_reset(2);
        issue_req(1'b1, 3'b111, 4'd15, 4'b0000, 0, "g15_pre_rst", t);
        for (int i = 0; i < 40 && cyc != t + 17; i++) @(negedge gclk);
        #1;
        checks++;
        if (cyc != t + 17 || col_en_cmp !== 4'b0011) begin
            errors++;
            $display("FAIL g15_col1 cyc=%0d cmp=%b required cyc %0d cmp 0011", cyc, col_en_cmp, t + 17);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge gclk);
        #1;
        rst = 1'b0;
        checks++;
        if ({col_en_jbus, col_en_ddr, col_en_cmp, busy, done} !== 14'd0) begin
            errors++;
            $display("FAIL rst_midramp got=%b required=0", {col_en_jbus, col_en_ddr, col_en_cmp, busy, done});
        end
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge gclk);
            if (done === 1'b1 || busy !== 1'b0) dn++;
        end
        checks++;
        if (dn != 0 || col_en_cmp !== 4'b0000) begin
            errors++;
            $display("FAIL rst_no_done stray_cycles=%0d cmp=%b required 0 0000", dn, col_en_cmp);
        end
        for (int dd = 0; dd < 3; dd++) m_en[dd] = 4'b0000;
        m_err = 1'b0;
        step(1);
    endtask

`ifdef BW_CLK_GL_SEQ_MASK_EN
    task automatic test_mask;
        int t, dc, dn;
        bit to;
        issue_req(1'b1, 3'b001, 4'd1, 4'b0101, 0, "mask_up", t);
        wait_drain(to, dc, dn);
        checks++;
        if (to || dc != t + 9 || col_en_cmp !== 4'b1010) begin
            errors++;
            $display("FAIL mask_up timeout=%0d done_cyc=%0d cmp=%b required cyc %0d cmp 1010", to, dc, col_en_cmp, t + 9);
        end
        step(1);
    endtask
`endif

    task automatic test_back_to_back;
        int t, dc, dn;
        bit to;
        issue_req(1'b1, 3'b001, 4'd1, 4'b0000, 4, "reassert", t);
        step(2);
        start_req = 1'b1;
        dom_sel   = 3'b111;
        step(1);
        start_req = 1'b0;
        wait_drain(to, dc, dn);
        checks++;
        if (to || dn != 1 || dc != t + 9 || err !== 1'b1 || col_en_ddr !== 4'b0000 || col_en_cmp !== 4'b1111) begin
            errors++;
            $display("FAIL reassert timeout=%0d done_count=%0d done_cyc=%0d err=%b ddr=%b cmp=%b required 1 %0d 1 0000 1111",
                     to, dn, dc, err, col_en_ddr, col_en_cmp, t + 9);
        end
        step(1);
    endtask

    initial begin
        rst       = 1'b1;
        start_req = 1'b0;
        stop_req  = 1'b0;
        dom_sel   = 3'b000;
        gap_cfg   = 4'd0;
        mask_drv  = 4'b0000;
        m_err     = 1'b0;
        for (int dd = 0; dd < 3; dd++) m_en[dd] = 4'b0000;
        test_reset();
        test_ramp_up_g2();
        test_idempotent();
        test_ramp_dn_g0();
        test_both_req();
        test_rst_midramp();
`ifdef BW_CLK_GL_SEQ_MASK_EN
        test_mask();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish before 20000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bw_clk_gl_seq.md
BW_CLK_GL_SEQ -- requirements
Module: bw_clk_gl_seq

Interface
REQ-001 SHALL be clocked by a single clock and reset synchronously, active-high; reset is sampled only on the rising edge of gclk.
REQ-002 SHALL have port: gclk  in  1  sequencer clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port: start_req  in  1  level request to ramp column clocks on; sampled only in IDLE.
REQ-005 SHALL have port: stop_req  in  1  level request to ramp column clocks off; sampled only in IDLE.
REQ-006 SHALL have port: dom_sel  in  3  domain select; bit0=cmp, bit1=ddr, bit2=jbus; latched at request acceptance.
REQ-007 SHALL have port: gap_cfg  in  4  inter-column gap G; each step occupies G+1 cycles; latched at request acceptance.
REQ-008 SHALL have port: col_mask  in  4  per-column skip mask; exists only when BW_CLK_GL_SEQ_MASK_EN is defined.
REQ-009 SHALL have ports: col_en_cmp, col_en_ddr, col_en_jbus  out  4 each  per-column clock enables for grid columns 0..3.
REQ-010 SHALL have ports: busy  out  1  high in any ramp state; done  out  1  one-cycle completion pulse; err  out  1  sticky protocol error.

Function
REQ-011 SHALL implement states IDLE, RAMP_UP, RAMP_DN, FINISH.
REQ-012 IDLE, start_req=1, stop_req=0: latch dom_sel and gap_cfg, set col_idx=0, go to RAMP_UP.
REQ-013 IDLE, stop_req=1, start_req=0: latch dom_sel and gap_cfg, set col_idx=3, go to RAMP_DN.
REQ-014 IDLE, start_req=1 and stop_req=1: no state change, set err.
REQ-015 Any start_req or stop_req high while busy=1: ignore it and set err; the ramp in progress continues unaffected.
REQ-016 RAMP_UP, first cycle of a step: set the col_idx bit of every selected domain's enable; deselected domains unchanged.
REQ-017 Each step lasts exactly G+1 cycles, counted by the gap timer; at step end col_idx increments (RAMP_UP) or decrements (RAMP_DN).
REQ-018 Latency: request sampled in cycle t gives column 0 enable visible in cycle t+1, and column k in cycle t+1+k*(G+1).
REQ-019 RAMP_DN: mirror of RAMP_UP, clearing enable bits in order col 3,2,1,0.
REQ-020 After the step for col 3 (up) or col 0 (down) ends: enter FINISH, assert done for one cycle, return to IDLE; busy is low in FINISH.
REQ-021 dom_sel=0 on an accepted request: perform all four steps with normal timing and no enable changes, then pulse done.
REQ-022 Ramping up already-enabled columns or down already-disabled columns is legal, idempotent, and does not set err.
REQ-023 G=0: one column per cycle; G=15: 16 cycles per column; the gap counter never wraps within a step.

Reset
REQ-024 While rst=1: state=IDLE; all col_en_* = 4'b0000; busy, done, err = 0; col_idx and gap counter = 0.
REQ-025 rst asserted mid-ramp: abort the ramp, clear all enables on the next edge, and emit no done pulse.
REQ-026 err SHALL clear only on rst.

Configuration
REQ-027 Macro BW_CLK_GL_SEQ_MASK_EN defined: col_mask is present and latched at acceptance; a step for a masked column still takes G+1 cycles but leaves that column's enables unchanged.
REQ-028 Macro BW_CLK_GL_SEQ_MASK_EN undefined: col_mask port is absent and all columns are sequenced.

Structure
REQ-029 Shared package bw_clk_gl_pkg SHALL hold the state enum, NUM_COL=4, NUM_DOM=3, GAP_W=4, and the domain bit indices.
REQ-030 The gap timer SHALL be a sub-module bw_clk_gl_seq_tmr (load G, count down, terminal pulse); all other logic lives in bw_clk_gl_seq.

Verification
REQ-031 Scenario 1: reset, then start_req in cycle 10 with dom_sel=3'b111, G=2 -> all three enables = 0001 at cycle 11, 0011 at 14, 0111 at 17, 1111 at 20; done at cycle 23.
REQ-032 Scenario 2: from all-on, stop_req with dom_sel=3'b010, G=0 -> col_en_ddr goes 0111, 0011, 0001, 0000 on consecutive cycles; cmp and jbus stay 1111; done 1 cycle later.
REQ-033 Scenario 3: start_req and stop_req together in IDLE -> err=1, state stays IDLE, enables unchanged; err is still 1 after a later clean ramp.
REQ-034 Scenario 4: start_req with G=15, rst pulsed after column 1 enables -> next cycle all enables 0, busy=0, no done pulse.
REQ-035 Scenario 5 (BW_CLK_GL_SEQ_MASK_EN): col_mask=4'b0101, dom_sel=3'b001, G=1 -> col_en_cmp ends 1010; done at the same cycle as the unmasked case.
REQ-036 Scenario 6: start_req re-asserted during RAMP_UP -> err=1, ramp timing unchanged, exactly one done pulse.
